// File: rtl/cordic_axil_ctrl.sv
// cordic_axil_ctrl: AXI4-Lite register front end for a CORDIC core.
// Holds operands, launches one operation at a time with a start/done
// handshake guarded by a watchdog, and exposes results, sticky status,
// an operation counter and a level interrupt.
module cordic_axil_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int OPW                = 16,
    parameter int TIMEOUT_CYC        = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              core_start,
    output logic                              core_mode,
    output logic [OPW-1:0]                    core_x,
    output logic [OPW-1:0]                    core_y,
    output logic [OPW-1:0]                    core_z,
    input  logic                              core_done,
    input  logic [OPW-1:0]                    core_xr,
    input  logic [OPW-1:0]                    core_yr,
    input  logic [OPW-1:0]                    core_zr,
    output logic                              irq
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [3:0] IDX_CTRL   = 4'd0;
    localparam logic [3:0] IDX_STATUS = 4'd1;
    localparam logic [3:0] IDX_X_IN   = 4'd2;
    localparam logic [3:0] IDX_Y_IN   = 4'd3;
    localparam logic [3:0] IDX_Z_IN   = 4'd4;
    localparam logic [3:0] IDX_X_OUT  = 4'd5;
    localparam logic [3:0] IDX_Y_OUT  = 4'd6;
    localparam logic [3:0] IDX_Z_OUT  = 4'd7;
    localparam logic [3:0] IDX_OPCNT  = 4'd8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e          state, state_nxt;

    logic            aw_held, w_held;
    logic [3:0]      aw_idx;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            bvalid, rvalid;
    logic [1:0]      bresp, rresp;
    logic [31:0]     rdata;

    logic            ctrl_mode, ctrl_irq_en;
    logic            st_done, st_timeout, st_overrun;
    logic [OPW-1:0]  x_in, y_in, z_in;
    logic [OPW-1:0]  x_out, y_out, z_out;
    logic [31:0]     opcnt;
    logic [WD_W-1:0] wdog;

    logic            wr_fire, wr_hit, start_wr, wdog_last;
    logic [2:0]      w1c;
    logic            busy, launch, finish_ok, finish_to, overrun_set;
    logic [31:0]     rd_data;
    logic            rd_hit;

    // Byte-address bits below the word index never select anything.
    logic            unused_addr_lsbs;
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Per-byte merge of a write into an existing 32-bit register image.
    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] upd,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? upd[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // A write is performed once both address and data are held; the held
    // flags stay set until then, so only one write is ever outstanding.
    assign S_AXI_AWREADY = ARESETN && !aw_held && !bvalid;
    assign S_AXI_WREADY  = ARESETN && !w_held && !bvalid;
    assign S_AXI_ARREADY = ARESETN && !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;

    assign wr_fire   = aw_held && w_held;
    assign wr_hit    = (aw_idx <= IDX_OPCNT);
    assign start_wr  = wr_fire && (aw_idx == IDX_CTRL) && wstrb_q[0] && wdata_q[0];
    assign w1c       = (wr_fire && (aw_idx == IDX_STATUS) && wstrb_q[0]) ? wdata_q[3:1] : 3'b000;
    assign wdog_last = (wdog == WD_W'(1));

    // Write channel: latch AW and W independently, then respond.
    always_ff @(posedge ACLK) begin
        // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
        if (!ARESETN) begin
            aw_held <= 1'b0;
            aw_idx  <= '0;
            w_held  <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[5:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                bvalid  <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: a completion beats a simultaneous watchdog expiry.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE: if (start_wr) state_nxt = S_RUN;
            S_RUN:  if (core_done || wdog_last) state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: decoded events that drive the datapath below.
    always_comb begin
        busy        = 1'b0;
        launch      = 1'b0;
        finish_ok   = 1'b0;
        finish_to   = 1'b0;
        overrun_set = 1'b0;
        case (state)
            S_IDLE: launch = start_wr;
            S_RUN: begin
                busy        = 1'b1;
                overrun_set = start_wr;
                finish_ok   = core_done;
                finish_to   = !core_done && wdog_last;
            end
        endcase
    end

    // Software-writable registers: CTRL fields and the operand inputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ctrl_mode   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            x_in        <= '0;
            y_in        <= '0;
            z_in        <= '0;
        end else if (wr_fire) begin
            case (aw_idx)
                IDX_CTRL: if (wstrb_q[0]) begin
                    ctrl_mode   <= wdata_q[1];
                    ctrl_irq_en <= wdata_q[2];
                end
                IDX_X_IN: x_in <= OPW'(byte_merge(32'(x_in), wdata_q, wstrb_q));
                IDX_Y_IN: y_in <= OPW'(byte_merge(32'(y_in), wdata_q, wstrb_q));
                IDX_Z_IN: z_in <= OPW'(byte_merge(32'(z_in), wdata_q, wstrb_q));
                default: ;
            endcase
        end
    end

    // Core launch, watchdog, result capture, counter and sticky status.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            core_x     <= '0;
            core_y     <= '0;
            core_z     <= '0;
            wdog       <= '0;
            x_out      <= '0;
            y_out      <= '0;
            z_out      <= '0;
            opcnt      <= '0;
            st_done    <= 1'b0;
            st_timeout <= 1'b0;
            st_overrun <= 1'b0;
        end else begin
            core_start <= launch;
            if (launch) begin
                // A START write always carries lane 0, so MODE comes from the same write.
                core_mode <= wdata_q[1];
                core_x    <= x_in;
                core_y    <= y_in;
                core_z    <= z_in;
                wdog      <= WD_W'(TIMEOUT_CYC);
            end else if (busy) begin
                wdog      <= wdog - WD_W'(1);
            end
            if (finish_ok) begin
                x_out <= core_xr;
                y_out <= core_yr;
                z_out <= core_zr;
                opcnt <= opcnt + 32'd1;
            end
            // Hardware set wins over a W1C in the same cycle.
            st_done    <= finish_ok   || (st_done    && !w1c[0]);
            st_timeout <= finish_to   || (st_timeout && !w1c[1]);
            st_overrun <= overrun_set || (st_overrun && !w1c[2]);
        end
    end

    // Interrupt is registered from the status bits, one cycle behind them.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) irq <= 1'b0;
        else          irq <= ctrl_irq_en && (st_done || st_timeout);
    end

    // Read decode: unmapped offsets return zero with SLVERR.
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        case (S_AXI_ARADDR[5:2])
            IDX_CTRL:   rd_data = {29'd0, ctrl_irq_en, ctrl_mode, 1'b0};
            IDX_STATUS: rd_data = {28'd0, st_overrun, st_timeout, st_done, busy};
            IDX_X_IN:   rd_data = 32'(x_in);
            IDX_Y_IN:   rd_data = 32'(y_in);
            IDX_Z_IN:   rd_data = 32'(z_in);
            IDX_X_OUT:  rd_data = 32'($signed(x_out));
            IDX_Y_OUT:  rd_data = 32'($signed(y_out));
            IDX_Z_OUT:  rd_data = 32'($signed(z_out));
            IDX_OPCNT:  rd_data = opcnt;
            default:    rd_hit  = 1'b0;
        endcase
    end

    // Read channel: capture data at the AR handshake and hold it until RREADY.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rvalid <= 1'b1;
            rdata  <= rd_data;
            rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cordic_axil_ctrl.sv
// tb_cordic_axil_ctrl: directed self-checking bench for cordic_axil_ctrl.
module tb_cordic_axil_ctrl;

    localparam int OPW = 16;
    localparam int TO  = 24;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic           ACLK = 1'b0;
    logic           ARESETN = 1'b0;
    logic [5:0]     S_AXI_AWADDR = '0;
    logic           S_AXI_AWVALID = 1'b0;
    logic           S_AXI_AWREADY;
    logic [31:0]    S_AXI_WDATA = '0;
    logic [3:0]     S_AXI_WSTRB = '0;
    logic           S_AXI_WVALID = 1'b0;
    logic           S_AXI_WREADY;
    logic [1:0]     S_AXI_BRESP;
    logic           S_AXI_BVALID;
    logic           S_AXI_BREADY = 1'b0;
    logic [5:0]     S_AXI_ARADDR = '0;
    logic           S_AXI_ARVALID = 1'b0;
    logic           S_AXI_ARREADY;
    logic [31:0]    S_AXI_RDATA;
    logic [1:0]     S_AXI_RRESP;
    logic           S_AXI_RVALID;
    logic           S_AXI_RREADY = 1'b0;
    logic           core_start, core_mode, irq;
    logic [OPW-1:0] core_x, core_y, core_z;
    logic           core_done = 1'b0;
    logic [OPW-1:0] core_xr = '0, core_yr = '0, core_zr = '0;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, start_cnt = 0, start_cyc = 0;

    always #5 ACLK = ~ACLK;

    cordic_axil_ctrl #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .OPW(OPW), .TIMEOUT_CYC(TO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .core_start(core_start), .core_mode(core_mode),
        .core_x(core_x), .core_y(core_y), .core_z(core_z),
        .core_done(core_done), .core_xr(core_xr), .core_yr(core_yr), .core_zr(core_zr),
        .irq(irq)
    );

    // Cycle counter and start-pulse monitor; start_cyc is the counter value
    // at the edge that sees core_start high.
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, required finish within bound");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // Full write; with pulse_done set, core_done is high exactly in the
    // cycle whose closing edge performs the register update.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit pulse_done, output logic [1:0] resp);
        bit aw_ok = 0, w_ok = 0, aw_hs, w_hs;
        int n = 0;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d;  S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        while (!(aw_ok && w_ok) && n < 50) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick; n++;
            if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_ok = 1; end
            if (w_hs)  begin S_AXI_WVALID  = 1'b0; w_ok  = 1; end
        end
        if (pulse_done) core_done = 1'b1;
        n = 0;
        while (!S_AXI_BVALID && n < 50) begin tick; core_done = 1'b0; n++; end
        core_done = 1'b0;
        resp = S_AXI_BRESP;
        check("wr_bvalid", 32'(S_AXI_BVALID), 32'd1);
        tick;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hs = 0;
        int n = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        while (!hs && n < 50) begin hs = S_AXI_ARREADY; tick; n++; end
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 50) begin tick; n++; end
        check("rd_rvalid", 32'(S_AXI_RVALID), 32'd1);
        d = S_AXI_RDATA; resp = S_AXI_RRESP;
        tick;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit pd, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(a, d, s, pd, r);
        check({tag, "_bresp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        check(tag, d, exp_d);
        check({tag, "_rresp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc != target && n < 1000) begin tick; n++; end
    endtask

    task automatic done_pulse;
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
    endtask

    initial begin
        bit hs;

        // ---- reset ----
        repeat (3) tick;
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_x", 32'(core_x), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        ARESETN = 1'b1;
        tick;
        for (int i = 0; i < 9; i++)
            rd_chk($sformatf("rst_reg_%0d", i), 6'(i * 4), 32'd0, OKAY);
        rd_chk("unmapped_rd_24", 6'h24, 32'd0, SLVERR);
        rd_chk("unmapped_rd_3c", 6'h3C, 32'd0, SLVERR);
        wr_chk("unmapped_wr", 6'h24, 32'hFFFF_FFFF, 4'hF, 0, SLVERR);

        // ---- operand registers ----
        wr_chk("x_in_wide", 6'h08, 32'hABCD_1234, 4'hF, 0, OKAY);
        rd_chk("x_in_trunc", 6'h08, 32'h0000_1234, OKAY);
        wr_chk("x_in_lane1", 6'h08, 32'h0000_5600, 4'h2, 0, OKAY);
        rd_chk("x_in_strb", 6'h08, 32'h0000_5634, OKAY);
        wr_chk("x_in", 6'h08, 32'h0000_1234, 4'hF, 0, OKAY);
        wr_chk("y_in", 6'h0C, 32'h0000_0000, 4'hF, 0, OKAY);
        wr_chk("z_in", 6'h10, 32'h0000_2000, 4'hF, 0, OKAY);
        wr_chk("ro_wr", 6'h14, 32'h0000_DEAD, 4'hF, 0, OKAY);
        rd_chk("ro_unchanged", 6'h14, 32'd0, OKAY);

        // ---- op1: rotation, result captured ----
        wr_chk("op1_start", 6'h00, 32'h5, 4'hF, 0, OKAY);
        check("op1_start_cnt", 32'(start_cnt), 32'd1);
        check("op1_core_x", 32'(core_x), 32'h1234);
        check("op1_core_y", 32'(core_y), 32'h0);
        check("op1_core_z", 32'(core_z), 32'h2000);
        check("op1_core_mode", 32'(core_mode), 32'd0);
        rd_chk("op1_busy", 6'h04, 32'h1, OKAY);
        rd_chk("op1_ctrl", 6'h00, 32'h4, OKAY);
        repeat (10) tick;
        core_xr = 16'hF000; core_yr = 16'h0123; core_zr = 16'h8001;
        done_pulse();
        check("op1_irq_lag", 32'(irq), 32'd0);
        tick;
        check("op1_irq", 32'(irq), 32'd1);
        rd_chk("op1_x_out", 6'h14, 32'hFFFF_F000, OKAY);
        rd_chk("op1_y_out", 6'h18, 32'h0000_0123, OKAY);
        rd_chk("op1_z_out", 6'h1C, 32'hFFFF_8001, OKAY);
        rd_chk("op1_status", 6'h04, 32'h2, OKAY);
        rd_chk("op1_opcnt", 6'h20, 32'd1, OKAY);
        wr_chk("op1_w1c", 6'h04, 32'h2, 4'hF, 0, OKAY);
        check("op1_irq_clear", 32'(irq), 32'd0);
        rd_chk("op1_status_clr", 6'h04, 32'h0, OKAY);

        // ---- core_done while idle is ignored ----
        core_xr = 16'h7777;
        done_pulse();
        rd_chk("idle_done_x", 6'h14, 32'hFFFF_F000, OKAY);
        rd_chk("idle_done_cnt", 6'h20, 32'd1, OKAY);
        rd_chk("idle_done_st", 6'h04, 32'h0, OKAY);

        // ---- op2: second START during RUN -> overrun ----
        wr_chk("op2_start", 6'h00, 32'h5, 4'hF, 0, OKAY);
        check("op2_start_cnt", 32'(start_cnt), 32'd2);
        repeat (2) tick;
        wr_chk("op2_restart", 6'h00, 32'h5, 4'hF, 0, OKAY);
        check("op2_no_restart", 32'(start_cnt), 32'd2);
        wr_chk("op2_x_in_run", 6'h08, 32'h0555, 4'hF, 0, OKAY);
        check("op2_core_x_held", 32'(core_x), 32'h1234);
        rd_chk("op2_busy_ovr", 6'h04, 32'h9, OKAY);
        core_xr = 16'h0042; core_yr = 16'hFFFE; core_zr = 16'h0001;
        done_pulse();
        rd_chk("op2_x_out", 6'h14, 32'h0000_0042, OKAY);
        rd_chk("op2_y_out", 6'h18, 32'hFFFF_FFFE, OKAY);
        rd_chk("op2_status", 6'h04, 32'hA, OKAY);
        rd_chk("op2_opcnt", 6'h20, 32'd2, OKAY);
        check("op2_irq", 32'(irq), 32'd1);
        wr_chk("op2_w1c_nolane0", 6'h04, 32'hE, 4'hE, 0, OKAY);
        rd_chk("op2_status_kept", 6'h04, 32'hA, OKAY);
        wr_chk("op2_w1c", 6'h04, 32'hE, 4'h1, 0, OKAY);
        rd_chk("op2_status_clr", 6'h04, 32'h0, OKAY);
        check("op2_irq_clear", 32'(irq), 32'd0);

        // ---- op3: W1C of DONE in the cycle DONE is set ----
        core_xr = 16'h0100;
        wr_chk("op3_start", 6'h00, 32'h1, 4'hF, 0, OKAY);
        wr_chk("op3_w1c_done", 6'h04, 32'h2, 4'hF, 1, OKAY);
        rd_chk("op3_status", 6'h04, 32'h2, OKAY);
        rd_chk("op3_opcnt", 6'h20, 32'd3, OKAY);
        check("op3_irq_masked", 32'(irq), 32'd0);
        wr_chk("op3_clr", 6'h04, 32'h2, 4'hF, 0, OKAY);

        // ---- op4: START in the same cycle as core_done ----
        wr_chk("op4_start", 6'h00, 32'h1, 4'hF, 0, OKAY);
        wr_chk("op4_restart_done", 6'h00, 32'h1, 4'hF, 1, OKAY);
        check("op4_start_cnt", 32'(start_cnt), 32'd4);
        rd_chk("op4_status", 6'h04, 32'hA, OKAY);
        rd_chk("op4_opcnt", 6'h20, 32'd4, OKAY);
        wr_chk("op4_clr", 6'h04, 32'hE, 4'hF, 0, OKAY);

        // ---- timeout A: still busy in the last watchdog cycle ----
        core_xr = 16'h7FFF;
        wr_chk("toa_start", 6'h00, 32'h3, 4'hF, 0, OKAY);
        check("toa_start_cnt", 32'(start_cnt), 32'd5);
        check("toa_core_mode", 32'(core_mode), 32'd1);
        wait_cyc(start_cyc + TO - 1);
        rd_chk("toa_busy_last", 6'h04, 32'h1, OKAY);
        repeat (4) tick;
        rd_chk("toa_status", 6'h04, 32'h4, OKAY);
        rd_chk("toa_opcnt", 6'h20, 32'd4, OKAY);
        rd_chk("toa_x_out", 6'h14, 32'h0000_0100, OKAY);
        wr_chk("toa_clr", 6'h04, 32'h4, 4'hF, 0, OKAY);

        // ---- timeout B: idle right after the watchdog expires ----
        wr_chk("tob_start", 6'h00, 32'h7, 4'hF, 0, OKAY);
        check("tob_start_cnt", 32'(start_cnt), 32'd6);
        wait_cyc(start_cyc + TO);
        rd_chk("tob_idle", 6'h04, 32'h4, OKAY);
        check("tob_irq", 32'(irq), 32'd1);
        rd_chk("tob_opcnt", 6'h20, 32'd4, OKAY);
        wr_chk("tob_clr", 6'h04, 32'h4, 4'hF, 0, OKAY);
        check("tob_irq_clear", 32'(irq), 32'd0);

        // ---- write channel: W early, B back-pressured ----
        S_AXI_WDATA = 32'h0000_0777; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        hs = S_AXI_WREADY;
        tick;
        if (hs) S_AXI_WVALID = 1'b0;
        check("wch_w_accepted", 32'(hs), 32'd1);
        check("wch_wready_held", 32'(S_AXI_WREADY), 32'd0);
        repeat (2) tick;
        check("wch_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("wch_no_bvalid", 32'(S_AXI_BVALID), 32'd0);
        S_AXI_AWADDR = 6'h0C; S_AXI_AWVALID = 1'b1;
        tick;
        S_AXI_AWVALID = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wch_bvalid_hold_%0d", i), 32'(S_AXI_BVALID), 32'd1);
            check($sformatf("wch_bresp_hold_%0d", i), 32'(S_AXI_BRESP), 32'(OKAY));
            check($sformatf("wch_awready_low_%0d", i), 32'(S_AXI_AWREADY), 32'd0);
            tick;
        end
        S_AXI_BREADY = 1'b1;
        tick;
        S_AXI_BREADY = 1'b0;
        check("wch_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
        tick;
        check("wch_single_resp", 32'(S_AXI_BVALID), 32'd0);
        rd_chk("wch_y_in", 6'h0C, 32'h0000_0777, OKAY);

        // ---- read channel: RDATA stable while RREADY is low ----
        S_AXI_ARADDR = 6'h20; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        tick;
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rch_rvalid_hold_%0d", i), 32'(S_AXI_RVALID), 32'd1);
            check($sformatf("rch_rdata_hold_%0d", i), S_AXI_RDATA, 32'd4);
            check($sformatf("rch_arready_low_%0d", i), 32'(S_AXI_ARREADY), 32'd0);
            tick;
        end
        S_AXI_RREADY = 1'b1;
        tick;
        S_AXI_RREADY = 1'b0;
        check("rch_rvalid_drop", 32'(S_AXI_RVALID), 32'd0);

        // ---- reset during RUN, then a stale core_done ----
        wr_chk("rst_run_start", 6'h00, 32'h5, 4'hF, 0, OKAY);
        check("rst_run_start_cnt", 32'(start_cnt), 32'd7);
        repeat (2) tick;
        ARESETN = 1'b0;
        tick;
        ARESETN = 1'b1;
        core_xr = 16'h1111;
        done_pulse();
        repeat (2) tick;
        rd_chk("rst_run_status", 6'h04, 32'h0, OKAY);
        rd_chk("rst_run_opcnt", 6'h20, 32'd0, OKAY);
        rd_chk("rst_run_x_out", 6'h14, 32'h0, OKAY);
        rd_chk("rst_run_ctrl", 6'h00, 32'h0, OKAY);
        rd_chk("rst_run_y_in", 6'h0C, 32'h0, OKAY);
        check("rst_run_core_x", 32'(core_x), 32'd0);
        check("rst_run_irq", 32'(irq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
